// File: rtl/writeback.sv
// writeback: commit stage that applies GPR or memory writes, owns architectural EFLAGS
// and counts retired instructions.
module writeback #(
    parameter logic [31:0] EFLAGS_RESET = 32'h0000_0002,
    parameter int          RETIRE_W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_result,
    input  logic [31:0]         in_eflags,
    input  logic [1:0]          in_dst_kind,
    input  logic [2:0]          in_dst_reg,
    input  logic [1:0]          in_dst_size,
    input  logic [31:0]         in_mem_addr,
    input  logic                flush,
    output logic                rf_we,
    output logic [2:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic [3:0]          rf_wmask,
    output logic                mem_wr_valid,
    input  logic                mem_wr_ready,
    output logic [31:0]         mem_wr_addr,
    output logic [31:0]         mem_wr_data,
    output logic [3:0]          mem_wr_mask,
    output logic [31:0]         eflags,
    output logic                retire,
    output logic [RETIRE_W-1:0] retire_count
);
    typedef enum logic [1:0] {IDLE, COMMIT, MEM} state_t;
    localparam logic [1:0] KIND_GPR = 2'd1;
    localparam logic [1:0] KIND_MEM = 2'd2;
    // Reserved-as-zero bits 3/5/15 and reserved-as-one bit 1
    localparam logic [31:0] EFL_ZERO = 32'h0000_8028;
    localparam logic [31:0] EFL_ONE  = 32'h0000_0002;

    state_t                state_q, state_d;
    logic [1:0]            kind_q;
    logic [31:0]           efl_q, eflags_q;
    logic [2:0]            rf_waddr_q;
    logic [31:0]           rf_wdata_q, mem_addr_q, mem_data_q;
    logic [3:0]            rf_wmask_q, mem_mask_q;
    logic [RETIRE_W-1:0]   cnt_q;
    logic                  accept, byte_hi;
    logic [31:0]           lane_data;
    logic [3:0]            lane_mask;

    assign accept  = (state_q == IDLE) && in_valid && !flush;
    assign byte_hi = (in_dst_size == 2'd0) && in_dst_reg[2];

    always_comb begin
        lane_mask = (in_dst_size == 2'd0) ? 4'b0001 : (in_dst_size == 2'd1) ? 4'b0011 : 4'b1111;
        lane_data = (in_dst_size == 2'd0) ? {24'b0, in_result[7:0]} :
                    (in_dst_size == 2'd1) ? {16'b0, in_result[15:0]} : in_result;
        state_d   = (state_q == IDLE) ? (accept ? ((in_dst_kind == KIND_MEM) ? MEM : COMMIT) : IDLE) :
                    (state_q == MEM && !mem_wr_ready) ? MEM : IDLE;
    end

    // Flush only squashes the single-cycle commit; a started memory handshake must finish
    assign retire       = ((state_q == COMMIT) && !flush) || ((state_q == MEM) && mem_wr_ready);
    assign rf_we        = (state_q == COMMIT) && !flush && (kind_q == KIND_GPR);
    assign mem_wr_valid = (state_q == MEM);
    assign in_ready     = (state_q == IDLE);
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign rf_wmask     = rf_wmask_q;
    assign mem_wr_addr  = mem_addr_q;
    assign mem_wr_data  = mem_data_q;
    assign mem_wr_mask  = mem_mask_q;
    assign eflags       = eflags_q;
    assign retire_count = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            kind_q     <= '0;
            efl_q      <= '0;
            eflags_q   <= EFLAGS_RESET;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_wmask_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_mask_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                eflags_q <= (efl_q | EFL_ONE) & ~EFL_ZERO;
                cnt_q    <= cnt_q + RETIRE_W'(1);
            end
            if (accept) begin
                kind_q <= in_dst_kind;
                efl_q  <= in_eflags;
            end
            if (accept && in_dst_kind == KIND_GPR) begin
                rf_waddr_q <= byte_hi ? {1'b0, in_dst_reg[1:0]} : in_dst_reg;
                rf_wdata_q <= byte_hi ? {16'b0, in_result[7:0], 8'b0} : lane_data;
                rf_wmask_q <= byte_hi ? 4'b0010 : lane_mask;
            end
            if (accept && in_dst_kind == KIND_MEM) begin
                mem_addr_q <= in_mem_addr;
                mem_data_q <= lane_data;
                mem_mask_q <= lane_mask;
            end
        end
    end
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed tests for the writeback commit stage.
module tb_writeback;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, flush = 0, mem_wr_ready = 0;
    logic [31:0] in_result = 0, in_eflags = 0, in_mem_addr = 0;
    logic [1:0]  in_dst_kind = 0, in_dst_size = 0;
    logic [2:0]  in_dst_reg = 0;
    logic        in_ready, rf_we, mem_wr_valid, retire;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata, mem_wr_addr, mem_wr_data, eflags, retire_count;
    logic [3:0]  rf_wmask, mem_wr_mask;
    int          tests = 0, fails = 0;
    logic [31:0] exp_cnt = 0;
    logic [31:0] b2b_res  [3] = '{32'h1111_1111, 32'hAAAA_BBBB, 32'h0000_0099};
    logic [2:0]  b2b_reg  [3] = '{3'd1, 3'd5, 3'd3};
    logic [1:0]  b2b_size [3] = '{2'd3, 2'd1, 2'd0};
    logic [31:0] b2b_data [3] = '{32'h1111_1111, 32'h0000_BBBB, 32'h0000_0099};
    logic [3:0]  b2b_mask [3] = '{4'b1111, 4'b0011, 4'b0001};

    writeback dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_eflags(in_eflags), .in_dst_kind(in_dst_kind),
        .in_dst_reg(in_dst_reg), .in_dst_size(in_dst_size), .in_mem_addr(in_mem_addr),
        .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_wmask(rf_wmask), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .eflags(eflags), .retire(retire), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [2:0] r, input logic [1:0] s,
                         input logic [31:0] res, input logic [31:0] a, input logic [31:0] e);
        in_valid = 1; in_dst_kind = k; in_dst_reg = r; in_dst_size = s;
        in_result = res; in_mem_addr = a; in_eflags = e;
    endtask

    task automatic test_reset();
        #12;
        tests++; if (eflags !== 32'h2) begin fails++; $display("FAIL reset_eflags got %h exp %h", eflags, 32'h2); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tests++; if (retire_count !== 32'h0) begin fails++; $display("FAIL reset_count got %h exp 0", retire_count); end
        tests++; if ({rf_we, mem_wr_valid, retire} !== 3'b000) begin fails++; $display("FAIL reset_strobes got %b exp 000", {rf_we, mem_wr_valid, retire}); end
        tests++; if ({rf_wdata, mem_wr_addr, mem_wr_data, rf_wmask, mem_wr_mask} !== '0) begin fails++; $display("FAIL reset_data got nonzero %h %h %h", rf_wdata, mem_wr_addr, mem_wr_data); end
        rst_n = 1;
        step();
    endtask

    task automatic test_gpr_high_byte();
        drive(2'd1, 3'd4, 2'd0, 32'h1234_56AB, 32'h0, 32'h0000_8AFF);
        step();
        in_valid = 0;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL gpr_in_ready got %b exp 0", in_ready); end
        tests++; if ({rf_we, retire} !== 2'b11) begin fails++; $display("FAIL gpr_we_retire got %b exp 11", {rf_we, retire}); end
        tests++; if (rf_waddr !== 3'd0) begin fails++; $display("FAIL gpr_waddr got %0d exp 0", rf_waddr); end
        tests++; if (rf_wmask !== 4'b0010) begin fails++; $display("FAIL gpr_mask got %b exp 0010", rf_wmask); end
        tests++; if (rf_wdata !== 32'h0000_AB00) begin fails++; $display("FAIL gpr_wdata got %h exp 0000ab00", rf_wdata); end
        tests++; if (eflags !== 32'h2) begin fails++; $display("FAIL gpr_eflags_early got %h exp 2", eflags); end
        step();
        exp_cnt++;
        tests++; if (eflags !== 32'h0000_0AD7) begin fails++; $display("FAIL gpr_eflags got %h exp 00000ad7", eflags); end
        tests++; if ({rf_we, retire, in_ready} !== 3'b001) begin fails++; $display("FAIL gpr_after got %b exp 001", {rf_we, retire, in_ready}); end
        tests++; if (retire_count !== exp_cnt) begin fails++; $display("FAIL gpr_count got %0d exp %0d", retire_count, exp_cnt); end
    endtask

    task automatic test_mem_stall();
        mem_wr_ready = 0;
        drive(2'd2, 3'd0, 2'd1, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0000_0001);
        step();
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (mem_wr_valid !== 1'b1) begin fails++; $display("FAIL mem_valid[%0d] got %b exp 1", i, mem_wr_valid); end
            tests++; if ({mem_wr_addr, mem_wr_data, mem_wr_mask} !== {32'h1000, 32'h0000_BEEF, 4'b0011}) begin fails++; $display("FAIL mem_payload[%0d] got %h %h %b exp 1000 0000beef 0011", i, mem_wr_addr, mem_wr_data, mem_wr_mask); end
            if (i == 3) mem_wr_ready = 1;
            #1;
            tests++; if (retire !== (i == 3)) begin fails++; $display("FAIL mem_retire[%0d] got %b exp %b", i, retire, i == 3); end
            step();
        end
        mem_wr_ready = 0;
        exp_cnt++;
        tests++; if (mem_wr_valid !== 1'b0) begin fails++; $display("FAIL mem_valid_drop got %b exp 0", mem_wr_valid); end
        tests++; if (eflags !== 32'h3) begin fails++; $display("FAIL mem_eflags got %h exp 3", eflags); end
        tests++; if (retire_count !== exp_cnt) begin fails++; $display("FAIL mem_count got %0d exp %0d", retire_count, exp_cnt); end
    endtask

    task automatic test_flush();
        drive(2'd1, 3'd2, 2'd2, 32'hCAFE_F00D, 32'h0, 32'h0000_0041);
        step();
        in_valid = 0; flush = 1;
        #1;
        tests++; if ({rf_we, retire} !== 2'b00) begin fails++; $display("FAIL flush_commit got %b exp 00", {rf_we, retire}); end
        step();
        flush = 0;
        tests++; if (eflags !== 32'h3) begin fails++; $display("FAIL flush_eflags got %h exp 3", eflags); end
        tests++; if (retire_count !== exp_cnt) begin fails++; $display("FAIL flush_count got %0d exp %0d", retire_count, exp_cnt); end
        drive(2'd1, 3'd0, 2'd2, 32'h1, 32'h0, 32'h0);
        flush = 1;
        step();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_idle_accept got in_ready %b exp 1", in_ready); end
        in_valid = 0; flush = 0;
        drive(2'd2, 3'd6, 2'd0, 32'h0000_0155, 32'h0000_2000, 32'h0000_0800);
        step();
        in_valid = 0; flush = 1;
        #1;
        tests++; if ({mem_wr_valid, retire, mem_wr_mask, mem_wr_data} !== {2'b10, 4'b0001, 32'h55}) begin fails++; $display("FAIL flush_mem_hold got %b %b %b %h exp 1 0 0001 55", mem_wr_valid, retire, mem_wr_mask, mem_wr_data); end
        step();
        mem_wr_ready = 1;
        #1;
        tests++; if ({mem_wr_valid, retire} !== 2'b11) begin fails++; $display("FAIL flush_mem_retire got %b exp 11", {mem_wr_valid, retire}); end
        step();
        mem_wr_ready = 0; flush = 0;
        exp_cnt++;
        tests++; if (eflags !== 32'h0000_0802) begin fails++; $display("FAIL flush_mem_eflags got %h exp 00000802", eflags); end
        tests++; if (retire_count !== exp_cnt) begin fails++; $display("FAIL flush_mem_count got %0d exp %0d", retire_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            tests++; if (in_ready !== (k % 2 == 0)) begin fails++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, in_ready, k % 2 == 0); end
            if (k % 2 == 0) drive(2'd1, b2b_reg[k/2], b2b_size[k/2], b2b_res[k/2], 32'h0, 32'h0);
            else begin
                tests++; if ({rf_we, rf_waddr, rf_wmask, rf_wdata} !== {1'b1, b2b_reg[k/2], b2b_mask[k/2], b2b_data[k/2]}) begin fails++; $display("FAIL b2b_write[%0d] got %b %0d %b %h exp 1 %0d %b %h", k, rf_we, rf_waddr, rf_wmask, rf_wdata, b2b_reg[k/2], b2b_mask[k/2], b2b_data[k/2]); end
            end
            step();
        end
        in_valid = 0;
        exp_cnt += 3;
        tests++; if (retire_count !== exp_cnt) begin fails++; $display("FAIL b2b_count got %0d exp %0d", retire_count, exp_cnt); end
        tests++; if (eflags !== 32'h2) begin fails++; $display("FAIL b2b_eflags got %h exp 2", eflags); end
    endtask

    task automatic test_reset_mid_mem();
        drive(2'd2, 3'd0, 2'd2, 32'h7777_7777, 32'h0000_3000, 32'h0000_00C1);
        step();
        in_valid = 0;
        tests++; if (mem_wr_valid !== 1'b1) begin fails++; $display("FAIL rstmem_valid got %b exp 1", mem_wr_valid); end
        #1 rst_n = 0;
        #1;
        tests++; if (mem_wr_valid !== 1'b0) begin fails++; $display("FAIL rstmem_drop got %b exp 0", mem_wr_valid); end
        tests++; if (retire_count !== 32'h0) begin fails++; $display("FAIL rstmem_count got %0d exp 0", retire_count); end
        tests++; if ({eflags, in_ready} !== {32'h2, 1'b1}) begin fails++; $display("FAIL rstmem_state got %h %b exp 2 1", eflags, in_ready); end
        #1 rst_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_gpr_high_byte();
        test_mem_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
